// File: rtl/playback_ctrl.sv
// Playback control: button edges -> play/pause, volume, track index; loader req/ack with timeout.
// Outputs change 1 cycle after a button edge is sampled; track_req is held until ack or timeout.
module playback_ctrl #(
  parameter int NUM_TRACKS  = 8,
  parameter int TRK_W       = 3,
  parameter int VOL_W       = 4,
  parameter int VOL_MAX     = 15,
  parameter int VOL_DEFAULT = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play_pause,
  input  logic             volume_up,
  input  logic             volume_down,
  input  logic             forward,
  input  logic             backward,
  input  logic             track_done,
  input  logic             track_ack,
  output logic             track_req,
  output logic [TRK_W-1:0] track_idx,
  output logic [VOL_W-1:0] volume,
  output logic             playing,
  output logic             busy,
  output logic             load_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TRK_W-1:0] IDX_LAST = TRK_W'(NUM_TRACKS - 1);
  localparam logic [VOL_W-1:0] VOL_TOP  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] VOL_RST  = VOL_W'(VOL_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_PAUSED,
    ST_PLAYING,
    ST_LOADING
  } state_e;

  // Button bit order: {play_pause, volume_up, volume_down, forward, backward}
  logic [4:0]       btn_cur_q, btn_prev_q;
  state_e           state_q, state_d;
  logic [TRK_W-1:0] idx_q, idx_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic             loaded_q, loaded_d;
  logic             resume_q, resume_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_err_q, load_err_d;

  logic evt_pp, evt_up, evt_dn, evt_fwd_btn, evt_bwd;
  logic evt_fwd, step_fwd, step_bwd, resume_tgl;
  logic [TRK_W-1:0] idx_inc, idx_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_cur_q  <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_cur_q  <= {play_pause, volume_up, volume_down, forward, backward};
      btn_prev_q <= btn_cur_q;
    end
  end

  assign evt_pp      = btn_cur_q[4] ^ btn_prev_q[4];
  assign evt_up      = btn_cur_q[3] & ~btn_prev_q[3];
  assign evt_dn      = btn_cur_q[2] & ~btn_prev_q[2];
  assign evt_fwd_btn = btn_cur_q[1] & ~btn_prev_q[1];
  assign evt_bwd     = btn_cur_q[0] & ~btn_prev_q[0];

  // End of track only advances while actually playing.
  assign evt_fwd  = evt_fwd_btn | (track_done & (state_q == ST_PLAYING));
  assign step_fwd = evt_fwd & ~evt_bwd;
  assign step_bwd = evt_bwd & ~evt_fwd;

  assign idx_inc    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign idx_dec    = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
  assign resume_tgl = resume_q ^ evt_pp;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vol_d      = vol_q;
    loaded_d   = loaded_q;
    resume_d   = resume_q;
    cnt_d      = cnt_q;
    load_err_d = 1'b0;

    if (evt_up && !evt_dn && vol_q != VOL_TOP) begin
      vol_d = vol_q + 1'b1;
    end else if (evt_dn && !evt_up && vol_q != '0) begin
      vol_d = vol_q - 1'b1;
    end

    case (state_q)
      ST_PAUSED: begin
        if (step_fwd || step_bwd) begin
          idx_d    = step_fwd ? idx_inc : idx_dec;
          resume_d = evt_pp;
          cnt_d    = '0;
          state_d  = ST_LOADING;
        end else if (evt_pp) begin
          if (loaded_q) begin
            state_d = ST_PLAYING;
          end else begin
            resume_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_LOADING;
          end
        end
      end
      ST_PLAYING: begin
        if (step_fwd || step_bwd) begin
          idx_d    = step_fwd ? idx_inc : idx_dec;
          resume_d = ~evt_pp;
          cnt_d    = '0;
          state_d  = ST_LOADING;
        end else if (evt_pp) begin
          state_d = ST_PAUSED;
        end
      end
      ST_LOADING: begin
        resume_d = resume_tgl;
        // An ack on the expiry cycle still counts as a successful load.
        if (track_ack) begin
          loaded_d = 1'b1;
          state_d  = resume_tgl ? ST_PLAYING : ST_PAUSED;
        end else if (cnt_q == CNT_LAST) begin
          loaded_d   = 1'b0;
          load_err_d = 1'b1;
          state_d    = ST_PAUSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PAUSED;
      idx_q      <= '0;
      vol_q      <= VOL_RST;
      loaded_q   <= 1'b0;
      resume_q   <= 1'b0;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vol_q      <= vol_d;
      loaded_q   <= loaded_d;
      resume_q   <= resume_d;
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end

  assign track_req = (state_q == ST_LOADING);
  assign busy      = (state_q == ST_LOADING);
  assign playing   = (state_q == ST_PLAYING);
  assign track_idx = idx_q;
  assign volume    = vol_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl: vector table for the basic flow, hand sequences for corners.
module tb_playback_ctrl;

  logic       clk;
  logic       rst_n;
  logic       play_pause, volume_up, volume_down, forward, backward;
  logic       track_done, track_ack;
  logic       track_req, playing, busy, load_err;
  logic [2:0] track_idx;
  logic [3:0] volume;

  int checks = 0;
  int errors = 0;
  logic pp_lvl = 1'b0;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] UP   = 4'b1000;
  localparam logic [3:0] DN   = 4'b0100;
  localparam logic [3:0] FWD  = 4'b0010;
  localparam logic [3:0] BWD  = 4'b0001;

  typedef struct packed {
    logic       pp;
    logic [3:0] btn;
    logic       done;
    logic       ack;
    logic [7:0] rep;
    logic [2:0] idx;
    logic [3:0] vol;
    logic       req;
    logic       play;
    logic       bsy;
    logic       err;
  } vec_t;

  vec_t tbl [18];

  playback_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play_pause (play_pause),
    .volume_up  (volume_up),
    .volume_down(volume_down),
    .forward    (forward),
    .backward   (backward),
    .track_done (track_done),
    .track_ack  (track_ack),
    .track_req  (track_req),
    .track_idx  (track_idx),
    .volume     (volume),
    .playing    (playing),
    .busy       (busy),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic pp, input logic [3:0] b, input logic d, input logic a,
                              input int rep, input int idx, input int vol,
                              input logic req, input logic play, input logic bsy, input logic err);
    vec_t v;
    v.pp = pp; v.btn = b; v.done = d; v.ack = a; v.rep = 8'(rep);
    v.idx = 3'(idx); v.vol = 4'(vol);
    v.req = req; v.play = play; v.bsy = bsy; v.err = err;
    return v;
  endfunction

  // Drive inputs at a falling edge and hold them for n rising edges.
  task automatic tick(input logic [3:0] b, input logic d, input logic a, input int n);
    play_pause = pp_lvl;
    {volume_up, volume_down, forward, backward} = b;
    track_done = d;
    track_ack  = a;
    repeat (n) @(negedge clk);
    track_done = 1'b0;
    track_ack  = 1'b0;
  endtask

  task automatic chk(input string nm, input int ei, input int ev,
                     input logic er, input logic ep, input logic eb, input logic ee);
    checks++;
    if ({track_idx, volume, track_req, playing, busy, load_err} !==
        {3'(ei), 4'(ev), er, ep, eb, ee}) begin
      errors++;
      $display("FAIL %s: got idx=%0d vol=%0d req=%0b play=%0b busy=%0b err=%0b, expected idx=%0d vol=%0d req=%0b play=%0b busy=%0b err=%0b",
               nm, track_idx, volume, track_req, playing, busy, load_err, ei, ev, er, ep, eb, ee);
    end
  endtask

  initial begin
    //             pp btn      dn ak rep idx vol req pl bsy err
    tbl[0]  = mk(1, NONE,    0, 0, 1,  0, 8,  0, 0, 0, 0);
    tbl[1]  = mk(1, NONE,    0, 0, 1,  0, 8,  1, 0, 1, 0);
    tbl[2]  = mk(1, NONE,    0, 0, 2,  0, 8,  1, 0, 1, 0);
    tbl[3]  = mk(1, NONE,    0, 1, 1,  0, 8,  0, 1, 0, 0);
    tbl[4]  = mk(1, UP,      0, 0, 1,  0, 8,  0, 1, 0, 0);
    tbl[5]  = mk(1, NONE,    0, 0, 1,  0, 9,  0, 1, 0, 0);
    tbl[6]  = mk(1, UP | DN, 0, 0, 1,  0, 9,  0, 1, 0, 0);
    tbl[7]  = mk(1, NONE,    0, 0, 1,  0, 9,  0, 1, 0, 0);
    tbl[8]  = mk(1, DN,      0, 0, 1,  0, 9,  0, 1, 0, 0);
    tbl[9]  = mk(1, NONE,    0, 0, 1,  0, 8,  0, 1, 0, 0);
    tbl[10] = mk(0, NONE,    0, 0, 1,  0, 8,  0, 1, 0, 0);
    tbl[11] = mk(0, NONE,    0, 0, 1,  0, 8,  0, 0, 0, 0);
    tbl[12] = mk(1, NONE,    0, 0, 2,  0, 8,  0, 1, 0, 0);
    tbl[13] = mk(1, BWD,     0, 0, 2,  7, 8,  1, 0, 1, 0);
    tbl[14] = mk(1, NONE,    0, 1, 1,  7, 8,  0, 1, 0, 0);
    tbl[15] = mk(1, FWD,     0, 0, 2,  0, 8,  1, 0, 1, 0);
    tbl[16] = mk(1, FWD,     0, 1, 1,  0, 8,  0, 1, 0, 0);
    tbl[17] = mk(1, NONE,    0, 0, 1,  0, 8,  0, 1, 0, 0);

    rst_n = 1'b0;
    play_pause = 0; volume_up = 0; volume_down = 0; forward = 0; backward = 0;
    track_done = 0; track_ack = 0;
    repeat (2) @(negedge clk);
    chk("reset_values", 0, 8, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      pp_lvl = tbl[i].pp;
      tick(tbl[i].btn, tbl[i].done, tbl[i].ack, int'(tbl[i].rep));
      chk($sformatf("row%0d", i), int'(tbl[i].idx), int'(tbl[i].vol),
          tbl[i].req, tbl[i].play, tbl[i].bsy, tbl[i].err);
    end

    // Volume saturation at both ends (state PLAYING idx0 vol8).
    for (int i = 0; i < 10; i++) begin tick(UP, 0, 0, 1); tick(NONE, 0, 0, 1); end
    chk("vol_sat_max", 0, 15, 0, 1, 0, 0);
    tick(UP, 0, 0, 1); tick(NONE, 0, 0, 1);
    chk("vol_stay_max", 0, 15, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin tick(DN, 0, 0, 1); tick(NONE, 0, 0, 1); end
    chk("vol_sat_zero", 0, 0, 0, 1, 0, 0);

    // forward and track_done land in the same cycle: one step only.
    tick(FWD, 0, 0, 1);
    tick(FWD, 1, 0, 1);
    chk("fwd_done_single_step", 1, 0, 1, 0, 1, 0);
    tick(NONE, 0, 0, 1);
    tick(FWD, 0, 0, 1);
    tick(NONE, 1, 0, 1);
    chk("fwd_dropped_in_loading", 1, 0, 1, 0, 1, 0);
    tick(NONE, 0, 1, 1);
    chk("ack_after_drop", 1, 0, 0, 1, 0, 0);
    tick(NONE, 1, 0, 1);
    chk("track_done_steps", 2, 0, 1, 0, 1, 0);
    tick(NONE, 0, 1, 1);
    chk("ack_after_done", 2, 0, 0, 1, 0, 0);

    // Ack timeout: track_req holds for ACK_TIMEOUT cycles, then load_err pulses.
    tick(FWD, 0, 0, 1);
    tick(NONE, 0, 0, 1);
    chk("timeout_entry", 3, 0, 1, 0, 1, 0);
    tick(NONE, 0, 0, 254);
    chk("timeout_last_wait", 3, 0, 1, 0, 1, 0);
    tick(NONE, 0, 0, 1);
    chk("timeout_err_pulse", 3, 0, 0, 0, 0, 1);
    tick(NONE, 0, 0, 1);
    chk("timeout_err_clear", 3, 0, 0, 0, 0, 0);
    pp_lvl = 1'b0;
    tick(NONE, 0, 0, 2);
    chk("reload_after_err", 3, 0, 1, 0, 1, 0);
    tick(NONE, 0, 1, 1);
    chk("reload_ack", 3, 0, 0, 1, 0, 0);

    // Ack arriving on the expiry cycle wins.
    tick(BWD, 0, 0, 1);
    tick(NONE, 0, 0, 1);
    chk("expiry_entry", 2, 0, 1, 0, 1, 0);
    tick(NONE, 0, 0, 254);
    tick(NONE, 0, 1, 1);
    chk("ack_at_expiry", 2, 0, 0, 1, 0, 0);
    tick(NONE, 0, 0, 1);
    chk("ack_at_expiry_no_err", 2, 0, 0, 1, 0, 0);

    // A held button counts once.
    tick(FWD, 0, 0, 50);
    chk("held_fwd_one_step", 3, 0, 1, 0, 1, 0);
    tick(FWD, 0, 1, 1);
    chk("held_fwd_ack", 3, 0, 0, 1, 0, 0);
    tick(FWD, 0, 0, 10);
    chk("held_fwd_no_repeat", 3, 0, 0, 1, 0, 0);
    tick(NONE, 0, 0, 1);

    // Reset asserted while loading clears outputs without waiting for a clock.
    tick(FWD, 0, 0, 2);
    chk("pre_reset_loading", 4, 0, 1, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("reset_async", 0, 8, 0, 0, 0, 0);
    play_pause = 0; volume_up = 0; volume_down = 0; forward = 0; backward = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(NONE, 0, 0, 5);
    chk("post_reset_idle", 0, 8, 0, 0, 0, 0);
    tick(NONE, 0, 1, 1);
    chk("ack_ignored_idle", 0, 8, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
